// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with hex or binary-to-decimal display.
// Ports:
//   CLK, RESET       - clock, synchronous active-high reset
//   VALUE, MODE      - value to show; MODE 0 = hex, 1 = unsigned decimal
//   BLANK_LZ, DP     - leading-zero blanking, per-digit decimal points
//   BRIGHT           - slot duty (BRIGHT+1)/16
//   CATHODE, ANODE   - registered segment and digit drives
//   BUSY             - capture/conversion in progress
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_FREQ   = 100000000,
    parameter int SCAN_HZ    = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    MODE,
    input  logic                    BLANK_LZ,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [3:0]              BRIGHT,
    output logic [7:0]              CATHODE,
    output logic [NUM_DIGITS-1:0]   ANODE,
    output logic                    BUSY
);

    localparam int W          = 4 * NUM_DIGITS;
    localparam int BCD_DIGITS = NUM_DIGITS + NUM_DIGITS / 4 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(W);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_RAW   = CLK_FREQ / (SCAN_HZ * 16);
    localparam int TICK_DIV   = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic             OUT_INV  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     cap_value_q;
    logic             cap_mode_q;
    logic             busy_q;
    logic [W-1:0]     shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_next;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     disp_q;
    logic             ovf_q;
    logic             changed;

    assign changed = (VALUE != cap_value_q) || (MODE != cap_mode_q);

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], shift_q[W-1]};
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (changed)
                    state_d = MODE ? CONVERT : COMMIT;
            end
            CONVERT: begin
                if (cnt_q == CNT_LAST)
                    state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cap_value_q <= '0;
            cap_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            disp_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (changed) begin
                        cap_value_q <= VALUE;
                        cap_mode_q  <= MODE;
                        busy_q      <= 1'b1;
                        shift_q     <= VALUE;
                        bcd_q       <= '0;
                        cnt_q       <= '0;
                    end
                end
                CONVERT: begin
                    shift_q <= shift_q << 1;
                    bcd_q   <= bcd_next;
                    cnt_q   <= cnt_q + 1'b1;
                end
                COMMIT: begin
                    busy_q <= 1'b0;
                    if (cap_mode_q) begin
                        disp_q <= bcd_q[W-1:0];
                        ovf_q  <= |bcd_q[BCD_W-1:W];
                    end else begin
                        disp_q <= cap_value_q;
                        ovf_q  <= 1'b0;
                    end
                end
                default: busy_q <= 1'b0;
            endcase
        end
    end

    assign BUSY = busy_q;

    logic [DIV_W-1:0] div_q;
    logic [3:0]       phase_q;
    logic [IDX_W-1:0] idx_q;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                phase_q <= phase_q + 4'd1;
                if (phase_q == 4'hF)
                    idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'h3F;
            4'h1:    seg7 = 7'h06;
            4'h2:    seg7 = 7'h5B;
            4'h3:    seg7 = 7'h4F;
            4'h4:    seg7 = 7'h66;
            4'h5:    seg7 = 7'h6D;
            4'h6:    seg7 = 7'h7D;
            4'h7:    seg7 = 7'h07;
            4'h8:    seg7 = 7'h7F;
            4'h9:    seg7 = 7'h6F;
            4'hA:    seg7 = 7'h77;
            4'hB:    seg7 = 7'h7C;
            4'hC:    seg7 = 7'h39;
            4'hD:    seg7 = 7'h5E;
            4'hE:    seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            nibble;
    logic                  blank;
    logic [6:0]            seg;
    logic [7:0]            cath_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    // lz[i]: digit i and every digit above it are zero.
    always_comb begin
        lz = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            lz[i] = ((disp_q >> (4 * i)) == '0);
    end

    always_comb begin
        nibble   = disp_q[4*idx_q +: 4];
        blank    = BLANK_LZ && !ovf_q && (idx_q != '0) && lz[idx_q];
        seg      = ovf_q ? 7'h40 : (blank ? 7'h00 : seg7(nibble));
        cath_raw = {DP[idx_q], seg};
        an_raw   = (phase_q <= BRIGHT) ? (AN_ONE << idx_q) : '0;
    end

    // Segments and anode are registered together so a new anode never
    // lights with the previous digit's pattern.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CATHODE <= {8{OUT_INV}};
            ANODE   <= {NUM_DIGITS{OUT_INV}};
        end else begin
            CATHODE <= OUT_INV ? ~cath_raw : cath_raw;
            ANODE   <= OUT_INV ? ~an_raw : an_raw;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (4 digits, one phase per cycle).
// Expected segment frames are queued on stimulus and popped per scanned slot.
module tb_seven_seg_scanner;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] VALUE = '0;
    logic        MODE = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [3:0]  DP = '0;
    logic [3:0]  BRIGHT = 4'd15;
    logic [7:0]  CATHODE;
    logic [3:0]  ANODE;
    logic        BUSY;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    seven_seg_scanner #(
        .NUM_DIGITS(4),
        .CLK_FREQ(1600),
        .SCAN_HZ(100),
        .ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .VALUE(VALUE),
        .MODE(MODE),
        .BLANK_LZ(BLANK_LZ),
        .DP(DP),
        .BRIGHT(BRIGHT),
        .CATHODE(CATHODE),
        .ANODE(ANODE),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b0111111;
            4'h1:    return 7'b0000110;
            4'h2:    return 7'b1011011;
            4'h3:    return 7'b1001111;
            4'h4:    return 7'b1100110;
            4'h5:    return 7'b1101101;
            4'h6:    return 7'b1111101;
            4'h7:    return 7'b0000111;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1101111;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b1111100;
            4'hC:    return 7'b0111001;
            4'hD:    return 7'b1011110;
            4'hE:    return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    function automatic logic [7:0] model_cath(input int unsigned v,
                                              input bit mode,
                                              input bit blz,
                                              input logic [3:0] dp,
                                              input int d);
        int unsigned p;
        logic [3:0] nib;
        logic [6:0] s;
        bit ovf;
        bit upper_zero;
        p = 1;
        for (int k = 0; k < d; k++)
            p = p * 10;
        ovf = mode && (v > 9999);
        if (mode) begin
            nib = 4'((v / p) % 10);
            upper_zero = ((v / p) == 0);
        end else begin
            nib = 4'(v >> (4 * d));
            upper_zero = ((v >> (4 * d)) == 0);
        end
        if (ovf)
            s = 7'b1000000;
        else if (blz && d != 0 && upper_zero)
            s = 7'b0000000;
        else
            s = seg_ref(nib);
        return ~{dp[d], s};
    endfunction

    task automatic push_frame(input int unsigned v, input bit mode,
                              input bit blz, input logic [3:0] dp);
        for (int d = 0; d < 4; d++)
            exp_q.push_back(model_cath(v, mode, blz, dp, d));
    endtask

    task automatic collect_frame(input string tag);
        logic [3:0]  prev;
        logic [3:0]  an_exp;
        logic [15:0] mask;
        logic [15:0] exp_mask;
        logic [7:0]  exp_c;
        int guard;
        guard = 0;
        do begin
            prev = ANODE;
            @(negedge CLK);
            guard++;
        end while (!(ANODE == 4'b1110 && prev != 4'b1110) && guard < 200);
        if (!(ANODE == 4'b1110 && prev != 4'b1110)) begin
            check({tag, "_sync"}, 32'(ANODE), 32'hE);
            for (int d = 0; d < 4 && exp_q.size() > 0; d++)
                void'(exp_q.pop_front());
            return;
        end
        exp_mask = 16'((32'h1 << (int'(BRIGHT) + 1)) - 1);
        for (int d = 0; d < 4; d++) begin
            an_exp = ~(4'b0001 << d);
            mask = '0;
            for (int c = 0; c < 16; c++) begin
                if (c == 0) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("%s_q_d%0d", tag, d), 0, 1);
                    end else begin
                        exp_c = exp_q.pop_front();
                        check($sformatf("%s_cath_d%0d", tag, d),
                              32'(CATHODE), 32'(exp_c));
                    end
                end
                mask[c] = (ANODE == an_exp);
                @(negedge CLK);
            end
            check($sformatf("%s_an_d%0d", tag, d), 32'(mask), 32'(exp_mask));
        end
    endtask

    task automatic measure_busy(input string tag, input int exp,
                                input int chg_at, input logic [15:0] chg_val);
        int n;
        int guard;
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (!BUSY && guard < 50);
        if (!BUSY) begin
            check({tag, "_start"}, 0, 1);
            return;
        end
        n = 0;
        while (BUSY && n < 100) begin
            n++;
            if (n == chg_at)
                VALUE = chg_val;
            @(negedge CLK);
        end
        check(tag, n, exp);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge CLK);
        check("rst_cath", 32'(CATHODE), 32'hFF);
        check("rst_an", 32'(ANODE), 32'hF);
        check("rst_busy", 32'(BUSY), 0);
        RESET = 1'b0;

        push_frame(0, 0, 0, 4'b0000);
        collect_frame("init");

        VALUE = 16'h1A2F;
        MODE = 1'b0;
        measure_busy("hex_busy", 1, 0, 16'h0);
        push_frame(32'h1A2F, 0, 0, 4'b0000);
        collect_frame("hex");

        VALUE = 16'd1234;
        MODE = 1'b1;
        measure_busy("dec_busy", 17, 0, 16'h0);
        push_frame(1234, 1, 0, 4'b0000);
        collect_frame("dec");

        VALUE = 16'd10000;
        measure_busy("ovf_busy", 17, 0, 16'h0);
        push_frame(10000, 1, 0, 4'b0000);
        collect_frame("ovf");

        VALUE = 16'd9999;
        measure_busy("max_busy", 17, 0, 16'h0);
        push_frame(9999, 1, 0, 4'b0000);
        collect_frame("max");

        BLANK_LZ = 1'b1;
        DP = 4'b0100;
        VALUE = 16'd7;
        measure_busy("blz7_busy", 17, 0, 16'h0);
        push_frame(7, 1, 1, 4'b0100);
        collect_frame("blz7");

        VALUE = 16'd0;
        measure_busy("blz0_busy", 17, 0, 16'h0);
        push_frame(0, 1, 1, 4'b0100);
        collect_frame("blz0");

        BRIGHT = 4'd3;
        push_frame(0, 1, 1, 4'b0100);
        collect_frame("br3");

        BRIGHT = 4'd0;
        push_frame(0, 1, 1, 4'b0100);
        collect_frame("br0");

        BRIGHT = 4'd15;
        BLANK_LZ = 1'b0;
        DP = 4'b0000;
        VALUE = 16'd500;
        measure_busy("rc_busy1", 17, 5, 16'd4321);
        measure_busy("rc_busy2", 17, 0, 16'h0);
        push_frame(4321, 1, 0, 4'b0000);
        collect_frame("rc");

        VALUE = 16'd1111;
        MODE = 1'b1;
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        VALUE = 16'd0;
        MODE = 1'b0;
        @(negedge CLK);
        check("abort_busy", 32'(BUSY), 0);
        check("abort_cath", 32'(CATHODE), 32'hFF);
        check("abort_an", 32'(ANODE), 32'hF);
        RESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (BUSY)
                seen++;
        end
        check("abort_idle", seen, 0);
        push_frame(0, 0, 0, 4'b0000);
        collect_frame("abort");

        MODE = 1'b1;
        measure_busy("m1_busy", 17, 0, 16'h0);
        push_frame(0, 1, 0, 4'b0000);
        collect_frame("m1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 The block SHALL have parameter CLK_FREQ, default 100000000, meaning the CLK frequency in Hz.
REQ-003 The block SHALL have parameter SCAN_HZ, default 1000, meaning the digit-slot rate in Hz.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, CATHODE and ANODE are inverted at the output.
REQ-005 Port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-007 Port VALUE, input, 4*NUM_DIGITS bits: the value to display.
REQ-008 Port MODE, input, 1 bit: 0 = hex, 1 = whole VALUE as unsigned decimal.
REQ-009 Port BLANK_LZ, input, 1 bit: 1 = blank leading zero digits.
REQ-010 Port DP, input, NUM_DIGITS bits: per-digit decimal point; bit i drives digit i.
REQ-011 Port BRIGHT, input, 4 bits: brightness, duty = (BRIGHT+1)/16.
REQ-012 Port CATHODE, output, 8 bits: segments, bit0=a .. bit6=g, bit7=dp; registered.
REQ-013 Port ANODE, output, NUM_DIGITS bits: one-hot digit enable, digit 0 = rightmost; registered.
REQ-014 Port BUSY, output, 1 bit: high while a capture or conversion is in progress.

Function
REQ-015 Capture FSM states SHALL be IDLE, CONVERT and COMMIT.
REQ-016 In IDLE, at any edge where {VALUE,MODE} differs from the captured copy, the block SHALL capture {VALUE,MODE}, set BUSY=1, and go to COMMIT if MODE=0, else CONVERT.
REQ-017 CONVERT SHALL run double-dabble one input bit per cycle, adjusting all BCD digits in parallel, for exactly 4*NUM_DIGITS cycles, then go to COMMIT.
REQ-018 The internal BCD width SHALL be NUM_DIGITS + NUM_DIGITS/4 + 1 digits.
REQ-019 COMMIT SHALL load the display register, clear BUSY and return to IDLE in one cycle.
REQ-020 Latency from the capture edge to the display update SHALL be 1 cycle for hex and 4*NUM_DIGITS+1 cycles for decimal.
REQ-021 BUSY SHALL be high for 1 cycle in hex mode and 4*NUM_DIGITS+1 cycles in decimal mode.
REQ-022 Decimal overflow: if any internal BCD digit at index NUM_DIGITS or above is nonzero, every displayed digit SHALL show a dash (segment g only).
REQ-023 VALUE or MODE changes outside IDLE SHALL be ignored; the next IDLE cycle re-compares, so the latest value is always converted.
REQ-024 Scan: a phase tick SHALL occur every CLK_FREQ/(SCAN_HZ*16) cycles; 16 phase ticks form one digit slot.
REQ-025 The digit index SHALL advance 0 to NUM_DIGITS-1 and wrap to 0 at the end of each slot.
REQ-026 ANODE SHALL be driven for the current digit only when phase <= BRIGHT; otherwise all anodes SHALL be off.
REQ-027 BRIGHT=15 SHALL give a full-on slot, and BRIGHT SHALL be sampled every cycle.
REQ-028 CATHODE SHALL be the standard hex pattern for the digit nibble, with bit7 = DP[index].
REQ-029 Leading-zero blanking, when BLANK_LZ=1: digits above the highest nonzero digit SHALL have segments a-g off with DP still honoured.
REQ-030 Leading-zero blanking SHALL never blank digit 0, and SHALL not apply to the dash display.
REQ-031 CATHODE and ANODE SHALL change only together, one cycle after the index/phase update, and SHALL never show the previous digit's segments on a new anode (no ghosting).

Reset
REQ-032 RESET SHALL force the FSM to IDLE, BUSY=0, captured copy = 0 (MODE 0), display register = 0, digit index = 0, phase = 0, and all anodes and segments off (CATHODE=ANODE=all ones when ACTIVE_LOW=1).
REQ-033 RESET asserted mid-conversion SHALL abort the conversion with no display update.
REQ-034 After reset, a nonzero VALUE or MODE=1 SHALL trigger a capture on the first IDLE edge.

Verification (NUM_DIGITS=4, CLK_FREQ=1600, SCAN_HZ=100, ACTIVE_LOW=1, so one phase per cycle and 16 cycles per slot)
REQ-035 Hex: VALUE=16'h1A2F, MODE=0, BRIGHT=15 -> BUSY high 1 cycle; digit0 CATHODE=8'h8E and digit3 CATHODE=8'hF9, each for 16 cycles, in order 0,1,2,3.
REQ-036 Decimal: VALUE=16'd1234, MODE=1 -> BUSY high 17 cycles; digits 3..0 show 1,2,3,4.
REQ-037 Overflow: VALUE=16'd10000, MODE=1 -> all four digits CATHODE=8'hBF; VALUE=16'd9999 -> 9,9,9,9.
REQ-038 Blanking: VALUE=16'd7, MODE=1, BLANK_LZ=1, DP=4'b0100 -> digits 3,1 CATHODE=8'hFF, digit2=8'h7F, digit0=8'hF8; VALUE=0 -> digit0=8'hC0.
REQ-039 Brightness: BRIGHT=3 -> each anode low exactly 4 of its 16 slot cycles, at phases 0-3; BRIGHT=0 -> 1 cycle.
REQ-040 Abort/re-compare: change VALUE at conversion cycle 5 -> the display shows the new value 17 cycles after the next IDLE capture; RESET at cycle 8 of a conversion -> display stays 0 and BUSY=0 on the next cycle.
